aes_decrypt_core: RTL and testbench

Iterative, handshaked AES decryption core for AES-128/192/256, selected by parameter. It accepts one 128-bit cyphertext block with its key over a valid/ready input port and runs one inverse round per clock through a single shared round datapath. The plaintext is returned on a valid/ready output port, with optional CBC chaining. It sits between the block-level input buffer and the output stream, and supersedes the free-running, enable-driven decryptor, which had no handshake, no reset and no chaining.

---
 rtl/aes_decrypt_core.sv | 239 +++++++++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_core
// Brief    : Iterative AES-128/192/256 decryption core with one inverse round
//            per clock, valid/ready ports and optional CBC chaining.
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt_core #(
    parameter int N   = 128,
    parameter int CBC = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   cyphertext,
    input  logic [N-1:0]   key,
    input  logic           iv_load,
    input  logic [127:0]   iv,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   plaintext,
    output logic           busy
);

    localparam int         c_NK = N / 32;
    localparam int         c_NR = c_NK + 6;
    localparam int         c_NW = 4 * (c_NR + 1);
    localparam logic [3:0] c_NR4 = 4'(c_NR);
    localparam logic [127:0] c_CHAIN_MASK = (CBC != 0) ? {128{1'b1}} : 128'd0;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ROUND = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    generate
        if (N != 128 && N != 192 && N != 256) begin : g_bad_key_size
            $error("aes_decrypt_core: N must be 128, 192 or 256");
        end
    endgenerate

    // ------------------------------------------------------------------
    // GF(2^8) helpers; S-boxes are derived from the field inverse and the
    // affine transform rather than stored as tables.
    // ------------------------------------------------------------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 (and 0 maps to 0)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        t = ginv(a);
        return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]}
                 ^ {t[3:0], t[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] u;
        u = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return ginv(u);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [128*(c_NR+1)-1:0] expand_key(input logic [N-1:0] k);
        logic [31:0]             w [c_NW];
        logic [31:0]             t;
        logic [7:0]              rc;
        logic [128*(c_NR+1)-1:0] rk;
        rc = 8'h01;
        for (int i = 0; i < c_NW; i++) begin
            if (i < c_NK) begin
                w[i] = k[N-1-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % c_NK == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = xt(rc);
                end else if (c_NK > 6 && i % c_NK == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-c_NK] ^ t;
            end
        end
        for (int j = 0; j <= c_NR; j++) begin
            rk[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        end
        return rk;
    endfunction

    // Byte b of the block sits at bits [127-8b -: 8]; row = b%4, column = b/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int b = 0; b < 16; b++) begin
            o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath
    // ------------------------------------------------------------------
    logic [1:0]              r_fsm;
    logic [127:0]            r_state;
    logic [3:0]              r_cnt;
    logic [N-1:0]            r_key;
    logic [127:0]            r_cin;
    logic [127:0]            r_chain;
    logic [127:0]            r_pt;

    logic [128*(c_NR+1)-1:0] w_sched;
    logic [127:0]            w_rkeys [c_NR+1];
    logic [3:0]              w_rk_idx;
    logic [127:0]            w_rk;
    logic [127:0]            w_ark;
    logic [127:0]            w_imc;

    // In IDLE the schedule tracks the incoming key so the accept edge can
    // already apply the last round key.
    assign w_sched = expand_key((r_fsm == c_ST_IDLE) ? key : r_key);

    generate
        for (genvar g = 0; g <= c_NR; g++) begin : g_rkey
            assign w_rkeys[g] = w_sched[128*g +: 128];
        end
    endgenerate

    // r_cnt is 0 in IDLE, so this selects key r at accept and key 0 in the last round.
    assign w_rk_idx = c_NR4 - r_cnt;
    assign w_rk     = w_rkeys[w_rk_idx];
    assign w_ark    = inv_sub_bytes(inv_shift_rows(r_state)) ^ w_rk;
    assign w_imc    = inv_mix_columns(w_ark);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= c_ST_IDLE;
            r_state <= '0;
            r_cnt   <= '0;
            r_key   <= '0;
            r_cin   <= '0;
            r_chain <= '0;
            r_pt    <= '0;
        end else begin
            case (r_fsm)
                c_ST_IDLE: begin
                    if (iv_load) r_chain <= iv;
                    if (in_valid) begin
                        r_key   <= key;
                        r_cin   <= cyphertext;
                        r_state <= cyphertext ^ w_rk;
                        r_cnt   <= 4'd1;
                        r_fsm   <= c_ST_ROUND;
                    end
                end
                c_ST_ROUND: begin
                    if (r_cnt == c_NR4) begin
                        r_pt    <= w_ark ^ (r_chain & c_CHAIN_MASK);
                        r_chain <= r_cin;
                        r_fsm   <= c_ST_DONE;
                    end else begin
                        r_state <= w_imc;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_fsm <= c_ST_IDLE;
                        r_cnt <= '0;
                    end
                end
                default: r_fsm <= c_ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == c_ST_IDLE);
    assign out_valid = (r_fsm == c_ST_DONE);
    assign busy      = (r_fsm == c_ST_ROUND) || (r_fsm == c_ST_DONE);
    assign plaintext = r_pt;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decrypt_core
// Brief    : Scoreboard bench for aes_decrypt_core (ECB 128/192/256, CBC-128).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_decrypt_core;

    typedef struct {
        int           id;
        logic [127:0] pt;
        int           acc;
        int           lat;
    } exp_t;

    localparam logic [127:0] c_PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] c_K128    = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] c_K192    = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] c_K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] c_KB      = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_IV0     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_CT1     = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] c_CT2     = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] c_PT1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] c_PT2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] c_DCT1    = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] c_PT3     = 128'h3b46777a7a37807f74ef6520eee86197;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ct;
    logic [127:0] k0;
    logic [191:0] k1;
    logic [255:0] k2;
    logic [127:0] k3;
    logic         iv_load;
    logic [127:0] iv;
    logic         out_ready;
    logic         vld    [4];
    logic         rdy    [4];
    logic         ov     [4];
    logic         bz     [4];
    logic [127:0] pt     [4];

    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    exp_t         sb [$];
    logic         prev_ov  [4];
    int           rise_cyc [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_decrypt_core #(.N(128), .CBC(0)) u_dut128 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .cyphertext(ct),
        .key(k0), .iv_load(iv_load), .iv(iv), .out_valid(ov[0]), .out_ready(out_ready),
        .plaintext(pt[0]), .busy(bz[0]));

    aes_decrypt_core #(.N(192), .CBC(0)) u_dut192 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .cyphertext(ct),
        .key(k1), .iv_load(iv_load), .iv(iv), .out_valid(ov[1]), .out_ready(out_ready),
        .plaintext(pt[1]), .busy(bz[1]));

    aes_decrypt_core #(.N(256), .CBC(0)) u_dut256 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .cyphertext(ct),
        .key(k2), .iv_load(iv_load), .iv(iv), .out_valid(ov[2]), .out_ready(out_ready),
        .plaintext(pt[2]), .busy(bz[2]));

    aes_decrypt_core #(.N(128), .CBC(1)) u_cbc128 (
        .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(rdy[3]), .cyphertext(ct),
        .key(k3), .iv_load(iv_load), .iv(iv), .out_valid(ov[3]), .out_ready(out_ready),
        .plaintext(pt[3]), .busy(bz[3]));

    // Monitor: pops the oldest expectation for a DUT on each output handshake.
    task automatic check_out(input int i);
        int k;
        k = -1;
        foreach (sb[j]) if (k < 0 && sb[j].id == i) k = j;
        n_tests++;
        if (k < 0) begin
            n_fail++;
            $display("FAIL unexpected_output dut%0d: got plaintext %h, nothing outstanding", i, pt[i]);
        end else begin
            if (pt[i] !== sb[k].pt) begin
                n_fail++;
                $display("FAIL plaintext dut%0d: got %h want %h", i, pt[i], sb[k].pt);
            end
            n_tests++;
            if (rise_cyc[i] - sb[k].acc != sb[k].lat) begin
                n_fail++;
                $display("FAIL latency dut%0d: got %0d want %0d", i, rise_cyc[i] - sb[k].acc, sb[k].lat);
            end
            sb.delete(k);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                prev_ov[i] = 1'b0;
            end else begin
                if (ov[i] && !prev_ov[i]) rise_cyc[i] = cyc;
                if (ov[i] && out_ready) check_out(i);
                prev_ov[i] = ov[i];
            end
        end
    end

    task automatic send(input int id, input logic [127:0] c, input logic [255:0] k,
                        input logic [127:0] exp, input bit push, input bit with_iv);
        int   waited;
        exp_t e;
        @(posedge clk); #1;
        ct = c;
        case (id)
            0:       k0 = k[127:0];
            1:       k1 = k[191:0];
            2:       k2 = k;
            default: k3 = k[127:0];
        endcase
        vld[id] = 1'b1;
        if (with_iv) iv_load = 1'b1;
        waited = 0;
        while (!rdy[id] && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!rdy[id]) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: in_ready got 0 want 1", id);
            vld[id] = 1'b0;
            iv_load = 1'b0;
        end else begin
            if (push) begin
                e.id  = id;
                e.pt  = exp;
                e.acc = cyc + 1;
                e.lat = (id == 1) ? 12 : (id == 2) ? 14 : 10;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            vld[id] = 1'b0;
            iv_load = 1'b0;
        end
    endtask

    task automatic drain(input int id);
        int n;
        for (int t = 0; t < 300; t++) begin
            n = 0;
            foreach (sb[j]) if (sb[j].id == id) n++;
            if (n == 0) return;
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout dut%0d: outstanding blocks got %0d want 0", id, n);
    endtask

    initial begin
        int waited;
        rst = 1'b1; out_ready = 1'b1; iv_load = 1'b0; iv = '0; ct = '0;
        k0 = '0; k1 = '0; k2 = '0; k3 = '0;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0; prev_ov[i] = 1'b0; rise_cyc[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (ov[i] !== 1'b0 || rdy[i] !== 1'b1 || bz[i] !== 1'b0 || pt[i] !== 128'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got ov=%b rdy=%b busy=%b pt=%h want 0 1 0 0",
                         i, ov[i], rdy[i], bz[i], pt[i]);
            end
        end
        @(posedge clk); #1 rst = 1'b0;

        // ECB, all key sizes; second AES-128 block is offered while busy
        send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, c_K128, c_PT_FIPS, 1, 0);
        send(0, 128'h3925841d02dc09fbdc118597196a0b32, c_KB,
             128'h3243f6a8885a308d313198a2e0370734, 1, 0);
        send(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, c_K192, c_PT_FIPS, 1, 0);
        send(2, 128'h8ea2b7ca516745bfeafc49904b496089, c_K256, c_PT_FIPS, 1, 0);
        for (int i = 0; i < 3; i++) drain(i);

        // Back-pressure
        @(posedge clk); #1 out_ready = 1'b0;
        send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, c_K128, c_PT_FIPS, 1, 0);
        waited = 0;
        while (!ov[0] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (!ov[0]) begin
            n_fail++;
            $display("FAIL out_valid_timeout dut0: out_valid got 0 want 1");
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_tests++;
            if (pt[0] !== c_PT_FIPS || rdy[0] !== 1'b0 || bz[0] !== 1'b1 || ov[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL hold dut0 cycle %0d: got pt=%h rdy=%b busy=%b ov=%b want %h 0 1 1",
                         c, pt[0], rdy[0], bz[0], ov[0], c_PT_FIPS);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (rdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL release dut0: got rdy=%b ov=%b want 1 0", rdy[0], ov[0]);
        end

        // CBC: iv loaded on the accept edge, stray iv_load while busy
        iv = c_IV0;
        send(3, c_CT1, c_KB, c_PT1, 1, 1);
        send(3, c_CT2, c_KB, c_PT2, 1, 0);
        @(posedge clk); #1 iv = {128{1'b1}}; iv_load = 1'b1;
        @(posedge clk); #1 iv_load = 1'b0; iv = '0;
        send(3, c_CT1, c_KB, c_PT3, 1, 0);
        drain(3);

        // Reset mid-round at cnt = 5
        send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, c_K128, c_PT_FIPS, 0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (ov[0] !== 1'b0 || rdy[0] !== 1'b1 || pt[0] !== 128'd0 || bz[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset dut0: got ov=%b rdy=%b pt=%h busy=%b want 0 1 0 0",
                     ov[0], rdy[0], pt[0], bz[0]);
        end
        @(posedge clk); #1 rst = 1'b0;
        send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, c_K128, c_PT_FIPS, 1, 0);
        send(3, c_CT1, c_KB, c_DCT1, 1, 0);
        drain(0);
        drain(3);

        // Stand-alone iv_load in IDLE, then the two-block chain
        @(posedge clk); #1 iv = c_IV0; iv_load = 1'b1;
        @(posedge clk); #1 iv_load = 1'b0; iv = '0;
        send(3, c_CT1, c_KB, c_PT1, 1, 0);
        send(3, c_CT2, c_KB, c_PT2, 1, 0);
        drain(3);

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: outstanding blocks got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
